ss_scan_decoder: RTL and testbench

//  Reverse path of the hex-to-7-segment driver: watches a multiplexed 7-segment display bus
//  (segment pattern plus one-hot digit select) and recovers the hex digits being shown.

---
 rtl/ss_scan_decoder.sv | 94 +++++++++
 tb/tb_ss_scan_decoder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ss_scan_decoder.sv
// ss_scan_decoder: recovers hex digits from a multiplexed 7-segment bus and frames one full scan
module ss_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              ss,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] out_hex,
  output logic [NUM_DIGITS-1:0]   out_blank,
  output logic [NUM_DIGITS-1:0]   out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  typedef enum logic {COLLECT, PRESENT} state_t;
  state_t                state, state_nxt;
  logic [6:0]            ss_q;
  logic [NUM_DIGITS-1:0] sel_q, mask, mask_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  onehot, same, cap, wr;
  logic [3:0]            dec_hex;
  logic                  dec_blank, dec_err;

  function automatic logic [5:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = 6'h00;
      7'h06: decode = 6'h01;
      7'h5B: decode = 6'h02;
      7'h4F: decode = 6'h03;
      7'h66: decode = 6'h04;
      7'h6D: decode = 6'h05;
      7'h7D: decode = 6'h06;
      7'h07: decode = 6'h07;
      7'h7F: decode = 6'h08;
      7'h67: decode = 6'h09;
      7'h77: decode = 6'h0A;
      7'h7C: decode = 6'h0B;
      7'h39: decode = 6'h0C;
      7'h5E: decode = 6'h0D;
      7'h79: decode = 6'h0E;
      7'h71: decode = 6'h0F;
      7'h00: decode = 6'h10;
      default: decode = 6'h20;
    endcase
  endfunction

  assign {dec_err, dec_blank, dec_hex} = decode(ss);
  assign onehot    = $onehot(dig_sel);
  assign same      = (ss == ss_q) && (dig_sel == sel_q);
  assign cnt_nxt   = !onehot ? '0 : !same ? CW'(1) : (cnt == CW'(STABLE_CYCLES)) ? cnt : cnt + 1'b1;
  // capture only on the 7->8 style transition so a saturated run never re-fires
  assign cap       = onehot && same && (cnt == CW'(STABLE_CYCLES - 1));
  assign wr        = cap && (state == COLLECT);
  assign out_valid = (state == PRESENT);

  always_comb begin
    state_nxt = state;
    mask_nxt  = mask;
    if (state == COLLECT) begin
      mask_nxt  = wr ? (mask | dig_sel) : mask;
      state_nxt = &mask ? PRESENT : COLLECT;
    end else if (out_ready) begin
      mask_nxt  = '0;
      state_nxt = COLLECT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      ss_q      <= '0;
      sel_q     <= '0;
      cnt       <= '0;
      mask      <= '0;
      out_hex   <= '0;
      out_blank <= '0;
      out_err   <= '0;
    end else begin
      state <= state_nxt;
      ss_q  <= ss;
      sel_q <= dig_sel;
      cnt   <= cnt_nxt;
      mask  <= mask_nxt;
      for (int i = 0; i < NUM_DIGITS; i++)
        if (wr && dig_sel[i]) begin
          out_hex[4*i +: 4] <= dec_hex;
          out_blank[i]      <= dec_blank;
          out_err[i]        <= dec_err;
        end
    end
  end
endmodule

// File: tb/tb_ss_scan_decoder.sv
// tb_ss_scan_decoder: directed scans with a frame scoreboard checked at each handshake
module tb_ss_scan_decoder;
  logic        clk = 0, rst_n = 0, out_ready = 1;
  logic [6:0]  ss = '0;
  logic [3:0]  dig_sel = '0;
  logic [15:0] out_hex;
  logic [3:0]  out_blank, out_err;
  logic        out_valid;
  typedef struct {logic [15:0] h; logic [3:0] b; logic [3:0] e;} frame_t;
  frame_t q[$];
  frame_t f;
  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  ss_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .ss(ss), .dig_sel(dig_sel), .out_hex(out_hex),
    .out_blank(out_blank), .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic [6:0] p, input logic [3:0] s, input int n);
    ss = p;
    dig_sel = s;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic scan4(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2, input logic [6:0] p3);
    apply(p0, 4'b0001, 8);
    apply(p1, 4'b0010, 8);
    apply(p2, 4'b0100, 8);
    apply(p3, 4'b1000, 8);
  endtask

  task automatic expect_frame(input logic [15:0] h, input logic [3:0] b, input logic [3:0] e);
    q.push_back('{h, b, e});
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while (q.size() != 0 && k < 100) begin @(posedge clk); #1; k++; end
    chk(nm, q.size(), 0);
  endtask

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_frame: got hex %0h, required no frame", out_hex);
      end else begin
        f = q.pop_front();
        chk("frame_hex", out_hex, f.h);
        chk("frame_blank", out_blank, f.b);
        chk("frame_err", out_err, f.e);
      end
    end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_hex", out_hex, 0);
    chk("rst_blank", out_blank, 0);
    chk("rst_err", out_err, 0);
    rst_n = 1;
    @(posedge clk); #1;
    // plain frame and one-cycle latency
    expect_frame(16'h1A2F, 4'b0000, 4'b0000);
    scan4(7'h71, 7'h5B, 7'h77, 7'h06);
    chk("t1_valid_early", out_valid, 0);
    apply(7'h00, 4'b0000, 1);
    chk("t1_valid_lat", out_valid, 1);
    drain("t1_drain");
    // digit 2 held one cycle short
    apply(7'h3F, 4'b0001, 8);
    apply(7'h06, 4'b0010, 8);
    apply(7'h7D, 4'b0100, 7);
    apply(7'h4F, 4'b1000, 8);
    apply(7'h00, 4'b0000, 4);
    chk("t2_no_frame", out_valid, 0);
    expect_frame(16'h3710, 4'b0000, 4'b0000);
    apply(7'h07, 4'b0100, 8);
    apply(7'h00, 4'b0000, 1);
    chk("t2_valid", out_valid, 1);
    drain("t2_drain");
    // multi-hot and idle select never capture
    apply(7'h5B, 4'b0001, 8);
    apply(7'h66, 4'b0010, 8);
    apply(7'h6D, 4'b1000, 8);
    apply(7'h3F, 4'b0110, 20);
    apply(7'h3F, 4'b0000, 20);
    chk("t3_no_frame", out_valid, 0);
    expect_frame(16'h5C42, 4'b0000, 4'b0000);
    apply(7'h39, 4'b0100, 8);
    apply(7'h00, 4'b0000, 1);
    chk("t3_valid", out_valid, 1);
    drain("t3_drain");
    // blank, lamp test, illegal pattern
    expect_frame(16'h0080, 4'b0001, 4'b0100);
    scan4(7'h00, 7'h7F, 7'h01, 7'h3F);
    apply(7'h00, 4'b0000, 1);
    drain("t4_drain");
    // backpressure: frame frozen, later scans discarded
    out_ready = 0;
    expect_frame(16'hA986, 4'b0000, 4'b0000);
    scan4(7'h7D, 7'h7F, 7'h67, 7'h77);
    apply(7'h00, 4'b0000, 2);
    chk("t5_valid", out_valid, 1);
    scan4(7'h79, 7'h71, 7'h5E, 7'h7C);
    apply(7'h00, 4'b0000, 16);
    chk("t5_valid_held", out_valid, 1);
    chk("t5_frozen", out_hex, 16'hA986);
    out_ready = 1;
    drain("t5_drain");
    expect_frame(16'h7431, 4'b0000, 4'b0000);
    scan4(7'h06, 7'h4F, 7'h66, 7'h07);
    apply(7'h00, 4'b0000, 1);
    drain("t5_next_drain");
    // reset mid-frame loses the partial mask
    apply(7'h3F, 4'b0001, 8);
    apply(7'h06, 4'b0010, 8);
    apply(7'h5B, 4'b0100, 8);
    ss = '0;
    dig_sel = '0;
    rst_n = 0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_hex", out_hex, 0);
    @(posedge clk); #1;
    rst_n = 1;
    apply(7'h4F, 4'b0001, 8);
    apply(7'h66, 4'b0010, 8);
    apply(7'h6D, 4'b0100, 8);
    apply(7'h00, 4'b0000, 2);
    chk("t6_no_frame", out_valid, 0);
    expect_frame(16'h6543, 4'b0000, 4'b0000);
    apply(7'h7D, 4'b1000, 8);
    apply(7'h00, 4'b0000, 1);
    chk("t6_valid", out_valid, 1);
    drain("t6_drain");
    apply(7'h00, 4'b0000, 4);
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
